// File: rtl/response_encoder.sv
// rtl/response_encoder.sv - frames an opcode, a fixed payload and an XOR checksum into a paced byte stream for the UART transmitter
// Build option: RESPONSE_ENCODER_ASCII_HEX_EN selects ':'-led ASCII-hex framing terminated by CR LF
module response_encoder #(
  parameter int         PAYLOAD_BYTES = 3,
  parameter logic [7:0] SOF_BYTE      = 8'hA5,
  parameter int         ACK_TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_opcode,
  input  logic [8*PAYLOAD_BYTES-1:0] req_payload,
  output logic [7:0]                 snd_data,
  output logic                       snd_ready,
  input  logic                       snd_busy,
  output logic                       frame_done
);

`ifdef RESPONSE_ENCODER_ASCII_HEX_EN
  localparam int FRAME_BYTES = 2 * (PAYLOAD_BYTES + 2) + 3;
`else
  localparam int FRAME_BYTES = PAYLOAD_BYTES + 3;
`endif
  localparam int IDX_W = $clog2(FRAME_BYTES);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [7:0]                 opcode_q, opcode_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic [7:0]                 snd_data_d;
  logic                       snd_ready_d, frame_done_d, req_ready_d;
  logic [7:0]                 chk, field_val, cur_byte;
  logic [IDX_W-1:0]           field_sel;
`ifdef RESPONSE_ENCODER_ASCII_HEX_EN
  logic [3:0]                 nibble;
  logic [7:0]                 hex_char;
`endif

  always_comb begin
    chk = opcode_q;
    for (int k = 0; k < PAYLOAD_BYTES; k++) chk = chk ^ payload_q[8*k +: 8];
  end

  // Fields are opcode, payload bytes, checksum; each occupies one or two frame positions.
  always_comb begin
    field_sel = idx_q - IDX_W'(1);
`ifdef RESPONSE_ENCODER_ASCII_HEX_EN
    field_sel = field_sel >> 1;
`endif
    field_val = opcode_q;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (field_sel == IDX_W'(k + 1)) field_val = payload_q[8*k +: 8];
    end
    if (field_sel == IDX_W'(PAYLOAD_BYTES + 1)) field_val = chk;
`ifdef RESPONSE_ENCODER_ASCII_HEX_EN
    nibble   = idx_q[0] ? field_val[7:4] : field_val[3:0];
    hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    if (idx_q == '0)                          cur_byte = 8'h3A;
    else if (idx_q == LAST_IDX - IDX_W'(1))   cur_byte = 8'h0D;
    else if (idx_q == LAST_IDX)               cur_byte = 8'h0A;
    else                                      cur_byte = hex_char;
`else
    cur_byte = (idx_q == '0) ? SOF_BYTE : field_val;
`endif
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    opcode_d     = opcode_q;
    payload_d    = payload_q;
    snd_data_d   = snd_data;
    snd_ready_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          opcode_d  = req_opcode;
          payload_d = req_payload;
          idx_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!snd_busy) begin
          snd_data_d  = cur_byte;
          snd_ready_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_BUSY;
        end
      end
      // A transmitter that never acknowledges still lets the frame drain after the timeout.
      WAIT_BUSY: begin
        if (snd_busy) begin
          state_d = WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_CNT) state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!snd_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      opcode_q   <= '0;
      payload_q  <= '0;
      snd_data   <= '0;
      snd_ready  <= 1'b0;
      frame_done <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      payload_q  <= payload_d;
      snd_data   <= snd_data_d;
      snd_ready  <= snd_ready_d;
      frame_done <= frame_done_d;
      req_ready  <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_response_encoder.sv
// tb/tb_response_encoder.sv - bench for response_encoder with a UART busy model and frame reference model
module tb_response_encoder;
  localparam int         N   = 3;
  localparam int         TMO = 16;
  localparam logic [7:0] SOF = 8'hA5;

  logic           clk = 1'b0, reset = 1'b0, req_valid = 1'b0, snd_busy = 1'b0;
  logic           req_ready, snd_ready, frame_done;
  logic [7:0]     req_opcode = '0, snd_data;
  logic [8*N-1:0] req_payload = '0;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  int fd_cnt = 0, fd_cyc = 0;
  int busy_mode = 0, busy_len = 20, busy_left = 0;
  logic [7:0] got_q[$], exp_q[$], t1_tab[$];
  int pcyc_q[$];
  logic [7:0] last_data = '0;
  logic prev_ready = 1'b0;

  response_encoder #(.PAYLOAD_BYTES(N), .SOF_BYTE(SOF), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_payload(req_payload), .snd_data(snd_data),
    .snd_ready(snd_ready), .snd_busy(snd_busy), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc_cyc = cyc;
  end

  // Monitor samples what the DUT saw at the last rising edge, then the UART model updates busy.
  always @(negedge clk) begin
    if (!reset) begin
      last_data = '0;
      prev_ready = 1'b0;
      busy_left = 0;
    end else begin
      if (snd_ready) begin
        chk("pulse_while_busy", {31'd0, snd_busy}, 0);
        chk("pulse_back_to_back", {31'd0, prev_ready}, 0);
        got_q.push_back(snd_data);
        pcyc_q.push_back(cyc);
        last_data = snd_data;
      end else if (snd_data !== last_data) begin
        chk("data_stable", {24'd0, snd_data}, {24'd0, last_data});
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      prev_ready = snd_ready;
    end
    case (busy_mode)
      1: snd_busy = 1'b0;
      2: snd_busy = 1'b1;
      default: begin
        if (snd_ready && reset) busy_left = busy_len;
        snd_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
    endcase
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete();
    pcyc_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic append_model(input logic [7:0] op, input logic [8*N-1:0] p);
    logic [7:0] f[$];
    logic [7:0] x;
    string s;
    f.push_back(op);
    for (int k = 0; k < N; k++) f.push_back(p[8*k +: 8]);
    x = '0;
    foreach (f[i]) x = x ^ f[i];
    f.push_back(x);
`ifdef RESPONSE_ENCODER_ASCII_HEX_EN
    exp_q.push_back(8'h3A);
    foreach (f[i]) begin
      s = $sformatf("%02X", f[i]);
      exp_q.push_back(s[0]);
      exp_q.push_back(s[1]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(SOF);
    foreach (f[i]) exp_q.push_back(f[i]);
`endif
  endtask

  task automatic request(input logic [7:0] op, input logic [8*N-1:0] p);
    int n;
    req_opcode = op;
    req_payload = p;
    req_valid = 1'b1;
    n = 0;
    do begin step(); n++; end while (req_ready && n < 200);
    chk("accept_timeout", {31'd0, req_ready}, 0);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (fd_cnt < target && n < 3000) begin step(); n++; end
    chk("done_timeout", {31'd0, fd_cnt >= target}, 1);
  endtask

  task automatic cmp_bytes(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int n, gap, rr_high, fd1, len1;
    logic [7:0] op, op2;
    logic [8*N-1:0] p, p2;

    step();
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_snd_ready", {31'd0, snd_ready}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_snd_data", {24'd0, snd_data}, 0);
    step();
    reset = 1'b1;
    step();

    // Directed frame with a transmitter that stays busy 20 cycles per byte.
`ifdef RESPONSE_ENCODER_ASCII_HEX_EN
    t1_tab = '{8'h3A, 8'h35, 8'h32, 8'h31, 8'h30, 8'h32, 8'h30, 8'h33, 8'h30, 8'h35, 8'h32, 8'h0D, 8'h0A};
`else
    t1_tab = '{8'hA5, 8'h52, 8'h10, 8'h20, 8'h30, 8'h52};
`endif
    busy_mode = 0; busy_len = 20;
    clear();
    request(8'h52, 24'h302010);
    wait_done(1);
    repeat (5) step();
    cmp_bytes("t1", t1_tab);
    chk("t1_frame_done_once", fd_cnt, 1);

    // Silent transmitter: each byte advances on the acknowledge timeout.
    busy_mode = 1;
    repeat (3) step();
    clear();
    op = 8'($urandom); p = 24'($urandom);
    append_model(op, p);
    request(op, p);
    wait_done(1);
    cmp_bytes("t3", exp_q);
    if (pcyc_q.size() > 0) chk("t3_latency", pcyc_q[0] - acc_cyc, 1);
    for (int i = 1; i < pcyc_q.size(); i++) begin
      gap = pcyc_q[i] - pcyc_q[i-1];
      chk($sformatf("t3_gap%0d_%0d", i, gap), {31'd0, (gap >= TMO) && (gap <= TMO + 3)}, 1);
    end

    // Back-to-back requests with req_valid held across the first frame.
    busy_mode = 0; busy_len = 3;
    step();
    clear();
    op = 8'($urandom); p = 24'($urandom);
    op2 = 8'($urandom); p2 = 24'($urandom);
    append_model(op, p);
    len1 = exp_q.size();
    append_model(op2, p2);
    request(op, p);
    req_valid = 1'b1;
    req_opcode = op2;
    req_payload = p2;
    rr_high = 0; n = 0;
    while (fd_cnt < 1 && n < 3000) begin
      step(); n++;
      if (req_ready && fd_cnt == 0) rr_high++;
    end
    fd1 = fd_cyc;
    chk("t4_ready_low_in_frame", rr_high, 0);
    n = 0;
    do begin step(); n++; end while (req_ready && n < 200);
    req_valid = 1'b0;
    wait_done(2);
    cmp_bytes("t4", exp_q);
    if (pcyc_q.size() > len1) chk("t4_second_after_done", {31'd0, pcyc_q[len1] > fd1}, 1);

    // Transmitter busy before the first byte.
    busy_mode = 2;
    repeat (2) step();
    clear();
    op = 8'($urandom); p = 24'($urandom);
    append_model(op, p);
    request(op, p);
    repeat (50) step();
    chk("t5_no_pulse_while_busy", got_q.size(), 0);
    busy_mode = 0; busy_len = 2;
    wait_done(1);
    cmp_bytes("t5", exp_q);

    // Reset in the middle of a frame abandons it.
    busy_mode = 0; busy_len = 4;
    repeat (6) step();
    clear();
    request(8'($urandom), 24'($urandom));
    n = 0;
    while (got_q.size() < 2 && n < 500) begin step(); n++; end
    chk("t6_reach_byte2", {31'd0, got_q.size() >= 2}, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_snd_ready", {31'd0, snd_ready}, 0);
    chk("t6_rst_frame_done", {31'd0, frame_done}, 0);
    chk("t6_rst_req_ready", {31'd0, req_ready}, 1);
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    clear();
    op = 8'($urandom); p = 24'($urandom);
    append_model(op, p);
    request(op, p);
    wait_done(1);
    cmp_bytes("t6", exp_q);
    chk("t6_fd_count", fd_cnt, 1);

    // Random frames against random transmitter busy lengths.
    for (int r = 0; r < 6; r++) begin
      busy_len = $urandom_range(1, 6);
      repeat (8) step();
      clear();
      op = 8'($urandom); p = 24'($urandom);
      append_model(op, p);
      request(op, p);
      wait_done(1);
      repeat (2) step();
      cmp_bytes($sformatf("rnd%0d", r), exp_q);
      chk($sformatf("rnd%0d_fd", r), fd_cnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
